// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: two requester ports, core-chain command/response and status of the arbiter
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    logic [ADDR_WIDTH-1:0] req0_addr, req1_addr, cmd_addr;
    logic [DATA_WIDTH-1:0] req0_data, req1_data, cmd_wdata;
    logic                  req0_rw, req1_rw, cmd_rw;
    logic                  req0_valid, req1_valid, cmd_valid;
    logic                  req0_ready, req1_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata, resp0_rdata, resp1_rdata;
    logic                  rsp_rw, resp0_rw, resp1_rw;
    logic                  rsp_valid, resp0_valid, resp1_valid;
    logic [CW-1:0]         outstanding;
    logic                  err;
    modport slave (
        input  req0_addr, req0_data, req0_rw, req0_valid,
        input  req1_addr, req1_data, req1_rw, req1_valid,
        output req0_ready, req1_ready,
        output cmd_addr, cmd_wdata, cmd_rw, cmd_valid,
        input  rsp_rdata, rsp_rw, rsp_valid,
        output resp0_rdata, resp0_rw, resp0_valid,
        output resp1_rdata, resp1_rw, resp1_valid,
        output outstanding, err
    );
    modport master (
        output req0_addr, req0_data, req0_rw, req0_valid,
        output req1_addr, req1_data, req1_rw, req1_valid,
        input  req0_ready, req1_ready,
        input  cmd_addr, cmd_wdata, cmd_rw, cmd_valid,
        output rsp_rdata, rsp_rw, rsp_valid,
        input  resp0_rdata, resp0_rw, resp0_valid,
        input  resp1_rdata, resp1_rw, resp1_valid,
        input  outstanding, err
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin sharing of one register-bus chain between two requesters
module bus_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic       clk,
    input logic       rst,
    bus_arbiter_if.slave b
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;
    logic                       last_grant, grant, can_issue, push, pop, head;
    logic [MAX_OUTSTANDING-1:0] tags;
    logic [AW-1:0]              wp, rp;
    logic [CW-1:0]              count;
    always_comb begin
        can_issue = count != CW'(MAX_OUTSTANDING);
        grant     = (b.req0_valid & b.req1_valid) ? ~last_grant : b.req1_valid;
        push      = b.req0_ready | b.req1_ready;
        pop       = b.rsp_valid & (count != '0);
        head      = tags[rp];
    end
    assign b.req0_ready  = can_issue & b.req0_valid & ~grant;
    assign b.req1_ready  = can_issue & b.req1_valid & grant;
    assign b.outstanding = count;
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant    <= 1'b1;
            tags          <= '0;
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            b.cmd_addr    <= '0;
            b.cmd_wdata   <= '0;
            b.cmd_rw      <= 1'b0;
            b.cmd_valid   <= 1'b0;
            b.resp0_rdata <= '0;
            b.resp0_rw    <= 1'b0;
            b.resp0_valid <= 1'b0;
            b.resp1_rdata <= '0;
            b.resp1_rw    <= 1'b0;
            b.resp1_valid <= 1'b0;
            b.err         <= 1'b0;
        end else begin
            b.cmd_valid <= push;
            if (push) begin
                b.cmd_addr  <= grant ? b.req1_addr : b.req0_addr;
                b.cmd_wdata <= grant ? b.req1_data : b.req0_data;
                b.cmd_rw    <= grant ? b.req1_rw : b.req0_rw;
                last_grant  <= grant;
                tags[wp]    <= grant;
                wp          <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            b.resp0_valid <= pop & ~head;
            b.resp1_valid <= pop & head;
            if (pop & ~head) begin
                b.resp0_rdata <= b.rsp_rdata;
                b.resp0_rw    <= b.rsp_rw;
            end
            if (pop & head) begin
                b.resp1_rdata <= b.rsp_rdata;
                b.resp1_rw    <= b.rsp_rw;
            end
            // a response with nothing in flight is a protocol error that stays flagged
            if (b.rsp_valid & (count == '0)) b.err <= 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven vectors plus directed multi-cycle sequences for bus_arbiter
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    bus_arbiter_if b ();
    bus_arbiter dut (.clk(clk), .rst(rst), .b(b));
    typedef struct {
        int v0, v1, a0, a1, rv, rd;
        int r0, r1, ev, ea, erw, p0, p1, erd, eo;
    } vec_t;
    vec_t tbl[11];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input int v0, input int v1, input int a0, input int a1, input int rv, input int rd);
        b.req0_valid = 1'(v0);
        b.req1_valid = 1'(v1);
        b.req0_addr  = 16'(a0);
        b.req1_addr  = 16'(a1);
        b.req0_data  = 16'(a0) ^ 16'h5A5A;
        b.req1_data  = 16'(a1) ^ 16'h5A5A;
        b.req0_rw    = 1'b0;
        b.req1_rw    = 1'b1;
        b.rsp_valid  = 1'(rv);
        b.rsp_rdata  = 16'(rd);
        b.rsp_rw     = 1'(rd & 1);
    endtask
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk("rst_cmd_valid", 32'(b.cmd_valid), 0);
        chk("rst_cmd_addr", 32'(b.cmd_addr), 0);
        chk("rst_cmd_wdata", 32'(b.cmd_wdata), 0);
        chk("rst_resp_valid", 32'({b.resp0_valid, b.resp1_valid}), 0);
        chk("rst_resp_rdata", 32'({b.resp0_rdata, b.resp1_rdata}), 0);
        chk("rst_outstanding", 32'(b.outstanding), 0);
        chk("rst_err", 32'(b.err), 0);
        rst = 1'b0;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 0);
        tbl[0]  = '{1, 1, 'h10, 'h20, 0, 0,       1, 0, 1, 'h10, 0, 0, 0, 0, 1};
        tbl[1]  = '{1, 1, 'h10, 'h20, 0, 0,       0, 1, 1, 'h20, 1, 0, 0, 0, 2};
        tbl[2]  = '{1, 1, 'h11, 'h21, 0, 0,       1, 0, 1, 'h11, 0, 0, 0, 0, 3};
        tbl[3]  = '{1, 1, 'h12, 'h22, 0, 0,       0, 1, 1, 'h22, 1, 0, 0, 0, 4};
        tbl[4]  = '{0, 0, 0, 0, 1, 'h1111,        0, 0, 0, 'h22, 1, 1, 0, 'h1111, 3};
        tbl[5]  = '{0, 0, 0, 0, 1, 'h2222,        0, 0, 0, 'h22, 1, 0, 1, 'h2222, 2};
        tbl[6]  = '{0, 0, 0, 0, 1, 'h3333,        0, 0, 0, 'h22, 1, 1, 0, 'h3333, 1};
        tbl[7]  = '{0, 0, 0, 0, 1, 'h4444,        0, 0, 0, 'h22, 1, 0, 1, 'h4444, 0};
        tbl[8]  = '{0, 1, 0, 'h30, 0, 0,          0, 1, 1, 'h30, 1, 0, 0, 0, 1};
        tbl[9]  = '{1, 1, 'h40, 'h31, 1, 'h5555,  1, 0, 1, 'h40, 0, 0, 1, 'h5555, 1};
        tbl[10] = '{0, 0, 0, 0, 1, 'h6666,        0, 0, 0, 'h40, 0, 1, 0, 'h6666, 0};
        do_reset();
        // contention, draining and push/pop overlap straight out of reset
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].rv, tbl[i].rd);
            #1;
            chk($sformatf("v%0d_ready0", i), 32'(b.req0_ready), tbl[i].r0);
            chk($sformatf("v%0d_ready1", i), 32'(b.req1_ready), tbl[i].r1);
            tick();
            chk($sformatf("v%0d_cmd_valid", i), 32'(b.cmd_valid), tbl[i].ev);
            chk($sformatf("v%0d_cmd_addr", i), 32'(b.cmd_addr), tbl[i].ea);
            chk($sformatf("v%0d_cmd_wdata", i), 32'(b.cmd_wdata), 32'(tbl[i].ea ^ 'h5A5A));
            chk($sformatf("v%0d_cmd_rw", i), 32'(b.cmd_rw), tbl[i].erw);
            chk($sformatf("v%0d_resp0_valid", i), 32'(b.resp0_valid), tbl[i].p0);
            chk($sformatf("v%0d_resp1_valid", i), 32'(b.resp1_valid), tbl[i].p1);
            if (tbl[i].p0 != 0) begin
                chk($sformatf("v%0d_resp0_rdata", i), 32'(b.resp0_rdata), tbl[i].erd);
                chk($sformatf("v%0d_resp0_rw", i), 32'(b.resp0_rw), tbl[i].erd & 1);
            end
            if (tbl[i].p1 != 0) begin
                chk($sformatf("v%0d_resp1_rdata", i), 32'(b.resp1_rdata), tbl[i].erd);
                chk($sformatf("v%0d_resp1_rw", i), 32'(b.resp1_rw), tbl[i].erd & 1);
            end
            chk($sformatf("v%0d_outstanding", i), 32'(b.outstanding), tbl[i].eo);
            chk($sformatf("v%0d_err", i), 32'(b.err), 0);
        end
        // single read
        do_reset();
        drive(1, 0, 'h0005, 0, 0, 0);
        #1;
        chk("rd_ready0", 32'(b.req0_ready), 1);
        chk("rd_ready1", 32'(b.req1_ready), 0);
        tick();
        chk("rd_cmd", 32'({b.cmd_valid, b.cmd_rw, b.cmd_addr}), 32'h20005);
        drive(0, 0, 0, 0, 1, 'hBEEF);
        tick();
        chk("rd_cmd_pulse", 32'(b.cmd_valid), 0);
        chk("rd_resp0", 32'({b.resp0_valid, b.resp0_rw, b.resp0_rdata}), 32'h3BEEF);
        chk("rd_resp1_valid", 32'(b.resp1_valid), 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("rd_resp0_hold", 32'({b.resp0_valid, b.resp0_rdata}), 32'h0BEEF);
        // fill the tag FIFO with no responses
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 'h100 + i, 0, 0, 0);
            tick();
            chk($sformatf("fill%0d_outstanding", i), 32'(b.outstanding), 32'(i + 1));
        end
        drive(1, 1, 'h200, 'h300, 0, 0);
        #1;
        chk("full_readies", 32'({b.req0_ready, b.req1_ready}), 0);
        tick();
        chk("full_no_issue", 32'(b.cmd_valid), 0);
        drive(1, 1, 'h200, 'h300, 1, 'h7777);
        #1;
        chk("full_pop_readies", 32'({b.req0_ready, b.req1_ready}), 0);
        tick();
        chk("full_pop_outstanding", 32'(b.outstanding), 7);
        chk("full_pop_resp0", 32'({b.resp0_valid, b.resp0_rdata}), 32'h17777);
        drive(1, 0, 'h200, 0, 0, 0);
        #1;
        chk("full_ready_back", 32'(b.req0_ready), 1);
        tick();
        chk("full_refill", 32'({b.cmd_valid, b.cmd_addr}), 32'h10200);
        chk("full_refill_outstanding", 32'(b.outstanding), 8);
        // push and pop together at occupancy 3, oldest tag belongs to requester 1
        do_reset();
        drive(0, 1, 0, 'h101, 0, 0);
        tick();
        drive(1, 0, 'h102, 0, 0, 0);
        tick();
        drive(1, 0, 'h103, 0, 0, 0);
        tick();
        chk("pp_pre_outstanding", 32'(b.outstanding), 3);
        drive(1, 0, 'h104, 0, 1, 'hABCD);
        #1;
        chk("pp_ready0", 32'(b.req0_ready), 1);
        tick();
        chk("pp_outstanding", 32'(b.outstanding), 3);
        chk("pp_cmd", 32'({b.cmd_valid, b.cmd_addr}), 32'h10104);
        chk("pp_resp_valid", 32'({b.resp0_valid, b.resp1_valid}), 1);
        chk("pp_resp1", 32'({b.resp1_rw, b.resp1_rdata}), 32'h1ABCD);
        drive(0, 0, 0, 0, 1, 'h1234);
        tick();
        chk("pp_next_resp", 32'({b.resp0_valid, b.resp1_valid, b.resp0_rdata}), 32'h21234);
        chk("pp_next_outstanding", 32'(b.outstanding), 2);
        // stray response on an empty FIFO
        do_reset();
        drive(0, 0, 0, 0, 1, 'h9999);
        tick();
        chk("stray_err", 32'(b.err), 1);
        chk("stray_no_resp", 32'({b.resp0_valid, b.resp1_valid}), 0);
        chk("stray_outstanding", 32'(b.outstanding), 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("stray_err_sticky", 32'(b.err), 1);
        // reset with four transactions in flight
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 'h500 + i, 'h600 + i, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("mid_pre_outstanding", 32'(b.outstanding), 4);
        do_reset();
        drive(0, 0, 0, 0, 1, 'h5555);
        tick();
        chk("mid_late_err", 32'(b.err), 1);
        chk("mid_late_no_resp", 32'({b.resp0_valid, b.resp1_valid}), 0);
        drive(0, 1, 0, 'h77, 0, 0);
        #1;
        chk("mid_ready1", 32'(b.req1_ready), 1);
        tick();
        chk("mid_cmd", 32'({b.cmd_valid, b.cmd_rw, b.cmd_addr}), 32'h30077);
        chk("mid_outstanding", 32'(b.outstanding), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single register-bus core chain between two host bridges, e.g. a UART bridge_rx and a second bridge.
- Arbitrates requests round-robin and issues them onto the chain, one per cycle at most.
- Records the issuing requester of each transaction in an in-order tag FIFO.
- Routes each response arriving from the chain end back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 16, bus data width
- MAX_OUTSTANDING, 8, tag FIFO depth; power of two, >= 2; maximum in-flight transactions

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0_addr_i  in  ADDR_WIDTH  requester 0 address
- req0_data_i  in  DATA_WIDTH  requester 0 write data
- req0_rw_i  in  1  requester 0 1=write, 0=read
- req0_valid_i  in  1  requester 0 request valid
- req0_ready_o  out  1  requester 0 request accepted this cycle
- req1_addr_i, req1_data_i, req1_rw_i, req1_valid_i, req1_ready_o  same as requester 0, for requester 1
- addr_o  out  ADDR_WIDTH  to core chain
- wdata_o  out  DATA_WIDTH  to core chain
- rw_o  out  1  to core chain
- valid_o  out  1  to core chain
- rdata_i  in  DATA_WIDTH  from chain end
- rw_i  in  1  from chain end
- valid_i  in  1  from chain end
- resp0_rdata_o  out  DATA_WIDTH  response to requester 0
- resp0_rw_o  out  1  response to requester 0
- resp0_valid_o  out  1  response to requester 0
- resp1_rdata_o, resp1_rw_o, resp1_valid_o  same as requester 0, for requester 1
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy
- err_o  out  1  sticky: response arrived with no outstanding tag

Behaviour:
- Reset: all outputs 0, tag FIFO empty, last_grant = 1 (requester 0 wins first contention), err_o cleared.
  - Reset mid-transaction discards all tags; responses that arrive afterwards set err_o.
- Arbitration (combinational, each cycle):
  - can_issue = (outstanding < MAX_OUTSTANDING).
  - If can_issue and exactly one reqN_valid_i is high, grant N.
  - If both are high, grant the one != last_grant.
  - reqN_ready_o = can_issue & grant==N & reqN_valid_i; at most one ready is high per cycle.
  - Handshake completes on valid & ready. Requesters hold addr, data and rw stable while valid is high and ready is low.
- Issue (registered, 1-cycle latency):
  - On a handshake, addr_o/wdata_o/rw_o take the granted requester's fields, valid_o=1 for exactly one cycle, last_grant <= N, and tag N is pushed.
  - No handshake: valid_o=0; addr_o/wdata_o/rw_o hold their previous value.
- Full FIFO:
  - When outstanding == MAX_OUTSTANDING, both readies are low, even if a pop occurs the same cycle.
  - Readiness returns the cycle after occupancy drops.
- Response (registered, 1-cycle latency):
  - On valid_i with FIFO non-empty: pop head tag T; next cycle respT_rdata_o=rdata_i, respT_rw_o=rw_i, respT_valid_o=1 for one cycle. The other response port's valid stays 0.
  - On valid_i with FIFO empty: no pop, no response pulse, err_o <= 1 until rst.
- Simultaneous push and pop in one cycle: occupancy unchanged; ordering is preserved. The chain returns responses strictly in issue order.
- resp*_rdata_o/resp*_rw_o hold their last values when not valid.
- outstanding_o updates on the cycle after each push/pop.
- Throughput: one issue and one response per cycle, sustained.

Test Plan:
- Single read: req0 valid, addr=0x0005, rw=0 -> req0_ready_o=1 same cycle; next cycle valid_o=1, addr_o=0x0005. Chain returns rdata_i=0xBEEF -> next cycle resp0_valid_o=1, rdata=0xBEEF; resp1_valid_o stays 0.
- Contention: both valid continuously after reset -> grants alternate 0,1,0,1. Responses with data 0x1111, 0x2222, 0x3333, 0x4444 route to resp0, resp1, resp0, resp1 in order.
- Full: withhold valid_i and issue 8 reqs -> outstanding_o=8, both readies 0. One valid_i -> occupancy 7; ready returns the following cycle.
- Simultaneous push/pop at occupancy 3 -> outstanding_o stays 3; the response goes to the oldest tag's requester.
- Stray response: valid_i with empty FIFO -> no resp pulse, err_o=1 and held until rst.
- Reset mid-flight: 4 outstanding, assert rst one cycle -> all outputs 0, outstanding_o=0. A late valid_i sets err_o; the next req1-only request is granted immediately.
